// File: rtl/amns_load_unit.sv
// Operand loader: streams 2*N coefficient words (A then B) into the operand RAM
// after a start pulse, then pulses done_o one cycle after the final write.
module amns_load_unit #(
    parameter int N           = 5,
    parameter int COEFF_WIDTH = 64,
    parameter int ADDR_WIDTH  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [COEFF_WIDTH-1:0] s_data_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic                   ram_we_o,
    output logic                   ram_sel_o,
    output logic [ADDR_WIDTH-1:0]  ram_addr_o,
    output logic [COEFF_WIDTH-1:0] ram_data_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_FLUSH,
        S_DONE
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic                   sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [COEFF_WIDTH-1:0] data_q, data_d;
    logic                   ready;
    logic                   handshake;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        sel_d     = sel_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ready     = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
        handshake = ready && s_valid_i;

        case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                if (start_i) state_d = S_LOAD_A;
            end
            S_LOAD_A, S_LOAD_B: begin
                if (handshake) begin
                    we_d   = 1'b1;
                    sel_d  = (state_q == S_LOAD_B);
                    addr_d = cnt_q;
                    data_d = s_data_i;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_RESET;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign s_ready_o  = ready;
    assign ram_we_o   = we_q;
    assign ram_sel_o  = sel_q;
    assign ram_addr_o = addr_q;
    assign ram_data_o = data_q;
    assign busy_o     = (state_q != S_RESET) && (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_amns_load_unit.sv
// Scoreboard bench for amns_load_unit: three instances (N=5, N=1, N=3) share the
// stream and reset; expected writes/done pulses are queued at stimulus time.
module tb_amns_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start;
    logic [63:0] s_data;
    logic        s_valid;
    logic [2:0]  ready, we, sel, busy, done;
    logic [2:0]  addr0;
    logic [0:0]  addr1;
    logic [1:0]  addr2;
    logic [63:0] data0, data1, data2;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          k;
        int          sel;
        int          addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        int k;
        int cyc;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    amns_load_unit #(.N(5), .COEFF_WIDTH(64)) dut0 (
        .clock_i(clk), .reset_i(reset), .start_i(start[0]), .s_data_i(s_data),
        .s_valid_i(s_valid), .s_ready_o(ready[0]), .ram_we_o(we[0]), .ram_sel_o(sel[0]),
        .ram_addr_o(addr0), .ram_data_o(data0), .busy_o(busy[0]), .done_o(done[0]));

    amns_load_unit #(.N(1), .COEFF_WIDTH(64)) dut1 (
        .clock_i(clk), .reset_i(reset), .start_i(start[1]), .s_data_i(s_data),
        .s_valid_i(s_valid), .s_ready_o(ready[1]), .ram_we_o(we[1]), .ram_sel_o(sel[1]),
        .ram_addr_o(addr1), .ram_data_o(data1), .busy_o(busy[1]), .done_o(done[1]));

    amns_load_unit #(.N(3), .COEFF_WIDTH(64)) dut2 (
        .clock_i(clk), .reset_i(reset), .start_i(start[2]), .s_data_i(s_data),
        .s_valid_i(s_valid), .s_ready_o(ready[2]), .ram_we_o(we[2]), .ram_sel_o(sel[2]),
        .ram_addr_o(addr2), .ram_data_o(data2), .busy_o(busy[2]), .done_o(done[2]));

    task automatic check(input bit ok, input string name, input string act, input string exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    function automatic int addr_of(input int k);
        case (k)
            0:       return int'(addr0);
            1:       return int'(addr1);
            default: return int'(addr2);
        endcase
    endfunction

    function automatic logic [63:0] data_of(input int k);
        case (k)
            0:       return data0;
            1:       return data1;
            default: return data2;
        endcase
    endfunction

    // Monitor: compares every presented write / done pulse with the scoreboard.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int k = 0; k < 3; k++) begin
                string act, exp;
                if (we[k]) begin
                    act = $sformatf("dut%0d sel=%0d addr=%0d data=%0h cyc=%0d",
                                    k, sel[k], addr_of(k), data_of(k), cyc);
                    if (wq.size() == 0) begin
                        check(1'b0, "write_unexpected", act, "no write");
                    end else begin
                        wr_t e;
                        e   = wq.pop_front();
                        exp = $sformatf("dut%0d sel=%0d addr=%0d data=%0h cyc=%0d",
                                        e.k, e.sel, e.addr, e.data, e.cyc);
                        check(act == exp, "write", act, exp);
                    end
                end
                if (done[k]) begin
                    act = $sformatf("dut%0d done cyc=%0d", k, cyc);
                    if (dq.size() == 0) begin
                        check(1'b0, "done_unexpected", act, "no done");
                    end else begin
                        dn_t d;
                        d   = dq.pop_front();
                        exp = $sformatf("dut%0d done cyc=%0d", d.k, d.cyc);
                        check(act == exp, "done", act, exp);
                    end
                end
            end
        end
    end

    // mode 0: valid held high, 1: valid toggles, 2: extra start pulse during LOAD_B.
    // abort_after > 0: one-cycle reset in the cycle after that many handshakes.
    task automatic run_load(input int k, input int n, input logic [63:0] base,
                            input int mode, input int abort_after);
        int idx, j, c0, first_hs, last_hs;
        idx = 0; j = 0; first_hs = -1; last_hs = -1;
        start[k] = 1'b1;
        c0 = cyc;
        @(negedge clk);
        check(busy[k] == 1'b0, "busy_idle", $sformatf("%0b", busy[k]), "0");
        @(posedge clk); #1;
        start[k] = 1'b0;
        while (idx < 2 * n && j < 100) begin
            s_valid  = (mode == 1) ? (j % 2 == 0) : 1'b1;
            s_data   = base + 64'(idx);
            start[k] = (mode == 2 && idx == n + 1);
            @(negedge clk);
            check(busy[k] == 1'b1, "busy_load", $sformatf("%0b", busy[k]), "1");
            check(ready[k] == 1'b1, "ready_load", $sformatf("%0b", ready[k]), "1");
            if (s_valid && ready[k]) begin
                wq.push_back('{k, (idx >= n) ? 1 : 0, idx % n, base + 64'(idx), cyc + 1});
                if (idx == 0) first_hs = cyc;
                last_hs = cyc;
                idx++;
            end
            j++;
            @(posedge clk); #1;
            if (abort_after > 0 && idx == abort_after) break;
        end
        s_valid  = 1'b0;
        start[k] = 1'b0;
        if (abort_after > 0) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            check(busy[k] == 1'b0, "busy_after_abort", $sformatf("%0b", busy[k]), "0");
            check(ready[k] == 1'b0, "ready_after_abort", $sformatf("%0b", ready[k]), "0");
            return;
        end
        check(idx == 2 * n, "handshake_count", $sformatf("%0d", idx), $sformatf("%0d", 2 * n));
        if (mode == 0) begin
            check(first_hs == c0 + 1, "first_handshake_cyc",
                  $sformatf("%0d", first_hs), $sformatf("%0d", c0 + 1));
            check(last_hs == c0 + 2 * n, "last_handshake_cyc",
                  $sformatf("%0d", last_hs), $sformatf("%0d", c0 + 2 * n));
        end
        dq.push_back('{k, last_hs + 2});
        @(negedge clk);
        check(ready[k] == 1'b0, "ready_flush", $sformatf("%0b", ready[k]), "0");
        check(busy[k] == 1'b1, "busy_flush", $sformatf("%0b", busy[k]), "1");
        @(posedge clk); #1;
        @(negedge clk);
        check(busy[k] == 1'b1, "busy_done", $sformatf("%0b", busy[k]), "1");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        start   = '0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check(ready[0] == 1'b0, "reset_ready", $sformatf("%0b", ready[0]), "0");
        check(we[0] == 1'b0, "reset_we", $sformatf("%0b", we[0]), "0");
        check(sel[0] == 1'b0, "reset_sel", $sformatf("%0b", sel[0]), "0");
        check(addr0 == 3'd0, "reset_addr", $sformatf("%0d", addr0), "0");
        check(data0 == 64'd0, "reset_data", $sformatf("%0h", data0), "0");
        check(busy[0] == 1'b0, "reset_busy", $sformatf("%0b", busy[0]), "0");
        check(done[0] == 1'b0, "reset_done", $sformatf("%0b", done[0]), "0");
        @(posedge clk); #1;
        @(posedge clk); #1;

        run_load(0, 5, 64'd1,     0, 0);  // data 1..10, back-to-back follows
        run_load(0, 5, 64'h100,   1, 0);
        run_load(0, 5, 64'h200,   2, 0);
        run_load(0, 5, 64'h300,   0, 3);
        run_load(0, 5, 64'h400,   0, 0);
        run_load(1, 1, 64'hA,     0, 0);
        run_load(2, 3, 64'h50,    1, 0);
        run_load(2, 3, 64'h60,    0, 0);

        repeat (4) @(posedge clk);
        #1;
        check(wq.size() == 0, "writes_drained", $sformatf("%0d", wq.size()), "0");
        check(dq.size() == 0, "dones_drained", $sformatf("%0d", dq.size()), "0");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
